// File: rtl/muldiv_sequencer_if.sv
// CPU-side port bundle of the multiply/divide sequencer.
//   start  : op request, held high (with op/a/b stable) while stall=1
//   op     : 00 MUL signed, 01 MUL unsigned, 10 DIV floor, 11 DIV unsigned
//   a, b   : operands (multiplicand/dividend, multiplier/divisor)
//   stall  : CPU stall request (combinational)
//   done   : one-cycle completion pulse; res_lo/res_hi valid in that cycle
//   res_lo : product low word or quotient
//   res_hi : product high word or remainder (H register value)
// Handshake: an op is accepted on a rising clock edge where the sequencer is
// idle and start=1. The result is delivered with the single-cycle done pulse.
// stall stays high from acceptance until the cycle before done. A start that
// is still high during the done cycle belongs to the completing op and is ignored.
interface muldiv_sequencer_if #(parameter int W = 32);
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         stall;
  logic         done;
  logic [W-1:0] res_lo;
  logic [W-1:0] res_hi;

  modport master (output start, op, a, b, input stall, done, res_lo, res_hi);
  modport slave  (input start, op, a, b, output stall, done, res_lo, res_hi);
endinterface

// File: rtl/muldiv_sequencer.sv
// Issue/sequencing stage between the CPU and the two-cycle multiplier, plus a
// W-step restoring divider.
//   clk, rst  : clock, asynchronous active-high reset
//   cpu       : CPU-side bundle (slave modport)
//   mul_run   : multiplier run; mul_u: multiplier unsigned select
//   mul_x/y   : latched operands to the multiplier
//   mul_stall : multiplier busy; mul_z: multiplier product (2W)
//   dbg_state : current FSM state (0 IDLE, 1 MUL, 2 DIV, 3 DONE)
module muldiv_sequencer #(
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             rst,
  muldiv_sequencer_if.slave cpu,
  output logic             mul_run,
  output logic             mul_u,
  output logic [W-1:0]     mul_x,
  output logic [W-1:0]     mul_y,
  input  logic             mul_stall,
  input  logic [2*W-1:0]   mul_z,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          neg;      // floor division of a negative dividend
  logic [W-1:0]  rem;
  logic [W-1:0]  quo;      // dividend bits shift out the top, quotient bits in at the bottom
  logic          done_r;
  logic [W-1:0]  res_lo_r;
  logic [W-1:0]  res_hi_r;

  // One restoring step on the current remainder/quotient pair.
  logic [W:0]   trial;
  logic [W:0]   diff;
  logic [W-1:0] rem_nx;
  logic [W-1:0] quo_nx;
  logic [W-1:0] fix_lo;
  logic [W-1:0] fix_hi;

  always_comb begin
    trial  = {rem, quo[W-1]};
    diff   = trial - {1'b0, mul_y};
    rem_nx = diff[W] ? trial[W-1:0] : diff[W-1:0];
    quo_nx = {quo[W-2:0], ~diff[W]};
    fix_lo = quo_nx;
    fix_hi = rem_nx;
    if (mul_y == '0) begin
      // Divide by zero: defined result, raw dividend as remainder.
      fix_lo = '1;
      fix_hi = mul_x;
    end else if (neg) begin
      if (rem_nx != '0) begin
        fix_lo = ~quo_nx;
        fix_hi = mul_y - rem_nx;
      end else begin
        fix_lo = ~quo_nx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      neg      <= 1'b0;
      rem      <= '0;
      quo      <= '0;
      done_r   <= 1'b0;
      res_lo_r <= '0;
      res_hi_r <= '0;
      mul_run  <= 1'b0;
      mul_u    <= 1'b0;
      mul_x    <= '0;
      mul_y    <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cpu.start) begin
            mul_x <= cpu.a;
            mul_y <= cpu.b;
            neg   <= (cpu.op == 2'b10) && cpu.a[W-1];
            quo   <= ((cpu.op == 2'b10) && cpu.a[W-1]) ? (~cpu.a + 1'b1) : cpu.a;
            rem   <= '0;
            if (cpu.op[1]) begin
              cnt   <= CW'(W);
              state <= S_DIV;
            end else begin
              mul_run <= 1'b1;
              mul_u   <= cpu.op[0];
              state   <= S_MUL;
            end
          end
        end
        S_MUL: begin
          if (!mul_stall) begin
            res_lo_r <= mul_z[W-1:0];
            res_hi_r <= mul_z[2*W-1:W];
            mul_run  <= 1'b0;
            done_r   <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DIV: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            res_lo_r <= fix_lo;
            res_hi_r <= fix_hi;
            done_r   <= 1'b1;
            state    <= S_DONE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign cpu.stall  = ((state == S_IDLE) && cpu.start) || (state == S_MUL) || (state == S_DIV);
  assign cpu.done   = done_r;
  assign cpu.res_lo = res_lo_r;
  assign cpu.res_hi = res_hi_r;
  assign dbg_state  = state;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
  localparam int W = 32;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DIV = 2'd2;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.W(W)) cpu ();
  logic           mul_run, mul_u, mul_stall;
  logic [W-1:0]   mul_x, mul_y;
  logic [2*W-1:0] mul_z;
  logic [1:0]     dbg_state;

  muldiv_sequencer #(.W(W)) dut (
    .clk(clk), .rst(rst), .cpu(cpu.slave),
    .mul_run(mul_run), .mul_u(mul_u), .mul_x(mul_x), .mul_y(mul_y),
    .mul_stall(mul_stall), .mul_z(mul_z), .dbg_state(dbg_state)
  );

  // two-cycle multiplier model: busy in the first run cycle
  logic s_flag;
  logic [2*W-1:0] ext_x, ext_y;
  always @(posedge clk or posedge rst)
    if (rst) s_flag <= 1'b0; else s_flag <= mul_run;
  always_comb begin
    ext_x     = mul_u ? {{W{1'b0}}, mul_x} : {{W{mul_x[W-1]}}, mul_x};
    ext_y     = mul_u ? {{W{1'b0}}, mul_y} : {{W{mul_y[W-1]}}, mul_y};
    mul_z     = ext_x * ext_y;
    mul_stall = mul_run & ~s_flag;
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: pops one expected {hi,lo} per done pulse
  always @(negedge clk) begin
    logic [2*W-1:0] e;
    if (!rst && cpu.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0 at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("res_lo", {{W{1'b0}}, cpu.res_lo}, {{W{1'b0}}, e[W-1:0]});
        check("res_hi", {{W{1'b0}}, cpu.res_hi}, {{W{1'b0}}, e[2*W-1:W]});
      end
    end
  end

  // driver: called at negedge+1 while the DUT is in IDLE or DONE
  logic [1:0] first_state;
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] lo, input logic [W-1:0] hi, input int exp_stall);
    int stalls;
    bit got;
    cpu.start = 1'b1;
    cpu.op    = op;
    cpu.a     = a;
    cpu.b     = b;
    exp_q.push_back({hi, lo});
    #1;
    stalls = cpu.stall ? 1 : 0;
    got    = 1'b0;
    for (int k = 0; k < W + 10; k++) begin
      @(negedge clk);
      #1;
      if (k == 0) first_state = dbg_state;
      if (dbg_state == ST_MUL) begin
        check("mul_run", {63'd0, mul_run}, 64'd1);
        check("mul_u", {63'd0, mul_u}, {63'd0, op[0]});
        check("mul_x", {{W{1'b0}}, mul_x}, {{W{1'b0}}, a});
        check("mul_y", {{W{1'b0}}, mul_y}, {{W{1'b0}}, b});
      end
      if (dbg_state == ST_DIV) check("div_run_low", {63'd0, mul_run}, 64'd0);
      if (cpu.stall) stalls++;
      if (cpu.done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=0 expected=1 at %0t", $time);
    end
    check("stall_cycles", 64'(stalls), 64'(exp_stall));
  endtask

  task automatic gap();
    cpu.start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    cpu.start = 1'b0;
    cpu.op = 2'b00;
    cpu.a = '0;
    cpu.b = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_state", {62'd0, dbg_state}, {62'd0, ST_IDLE});
    check("rst_done", {63'd0, cpu.done}, 64'd0);
    check("rst_stall", {63'd0, cpu.stall}, 64'd0);
    check("rst_mul_run", {63'd0, mul_run}, 64'd0);
    check("rst_mul_u", {63'd0, mul_u}, 64'd0);
    check("rst_res", {cpu.res_hi, cpu.res_lo}, 64'd0);
    check("rst_mul_xy", {mul_x, mul_y}, 64'd0);
    rst = 1'b0;
    gap();

    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 3);     gap();
    run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'h0000_0001, 3);     gap();
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFC, 32'd1, W + 1);         gap();
    run_op(2'b10, 32'd7, 32'd2, 32'd3, 32'd1, W + 1);                         gap();
    run_op(2'b10, 32'hFFFF_FFF8, 32'd2, 32'hFFFF_FFFC, 32'd0, W + 1);         gap();
    run_op(2'b11, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 32'd2, W + 1);         gap();
    run_op(2'b11, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, W + 1);                 gap();
    run_op(2'b10, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, W + 1); gap();

    // back-to-back with start held high
    run_op(2'b00, 32'd100, 32'hFFFF_FFFD, 32'hFFFF_FED4, 32'hFFFF_FFFF, 3);
    run_op(2'b11, 32'd100, 32'd7, 32'd14, 32'd2, W + 1);
    check("b2b_one_idle", {62'd0, first_state}, {62'd0, ST_IDLE});
    gap();

    // reset in the DIV cycle where the counter reads 10
    cpu.start = 1'b1;
    cpu.op    = 2'b11;
    cpu.a     = 32'd1000;
    cpu.b     = 32'd3;
    repeat (W - 9) @(negedge clk);
    #1;
    check("mid_div_state", {62'd0, dbg_state}, {62'd0, ST_DIV});
    rst = 1'b1;
    cpu.start = 1'b0;
    #1;
    check("mid_rst_stall", {63'd0, cpu.stall}, 64'd0);
    check("mid_rst_mul_run", {63'd0, mul_run}, 64'd0);
    check("mid_rst_done", {63'd0, cpu.done}, 64'd0);
    check("mid_rst_res", {cpu.res_hi, cpu.res_lo}, 64'd0);
    check("mid_rst_state", {62'd0, dbg_state}, {62'd0, ST_IDLE});
    @(negedge clk);
    rst = 1'b0;
    repeat (W + 4) @(negedge clk);
    #1;
    run_op(2'b01, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd1, 3);
    gap();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
